// File: rtl/gate_check_pkg.sv
// -----------------------------------------------------------------------------
// gate_check_pkg
// Shared definitions for the 2-input gate response checker:
//   - op encodings: OP_AND, OP_OR, OP_XOR, OP_NAND
//   - state_t: FSM state type and its encodings (plain localparams, so the
//     values stay fixed and can be read directly in legacy waveform viewers)
//   - expected_out(op, a, b): pure function giving the reference gate output
// -----------------------------------------------------------------------------
package gate_check_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WAIT   = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  function automatic logic expected_out(input logic [1:0] op,
                                        input logic       a,
                                        input logic       b);
    logic res;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = ~(a & b);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// -----------------------------------------------------------------------------
// gate_ref_model
// Combinational reference for the team's 2-input primitive gates.
// Ports:
//   op    in  2  function select (OP_AND/OP_OR/OP_XOR/OP_NAND)
//   a, b  in  1  gate inputs
//   y_exp out 1  expected gate output
// -----------------------------------------------------------------------------
module gate_ref_model
  import gate_check_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y_exp
);

  assign y_exp = expected_out(op, a, b);

endmodule

// File: rtl/gate_checker.sv
// -----------------------------------------------------------------------------
// gate_checker
// Response monitor for a 2-input gate under test. Accepts one vector per
// sample_valid handshake, waits SETTLE_CYCLES, samples y and compares it with
// the reference model. Counts vectors and mismatches (saturating), tracks
// which of the four {a,b} combinations have been checked, and raises
// done/pass once all four are covered.
//
// Parameters:
//   SETTLE_CYCLES  cycles between acceptance and sampling of y (0 legal)
//   CNT_W          width of vec_cnt / fail_cnt
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   start              pulse: clear results, latch op, begin a run
//   op[1:0]            expected function, latched on start
//   sample_valid,a,b   applied vector handshake
//   y                  observed gate output
//   busy               in WAIT, SETTLE or CHECK
//   done, pass         all four combinations checked / and no mismatches
//   vec_cnt, fail_cnt  vectors checked / mismatches
//   coverage[3:0]      bit {a,b} set once that combination was checked
//   first_fail[2:0]    {a,b,y} of the first mismatch of a run
//                      (only when GATE_CHECKER_CAPTURE_EN is defined)
// -----------------------------------------------------------------------------
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sample_valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       coverage
`ifdef GATE_CHECKER_CAPTURE_EN
  ,
  output logic [2:0]       first_fail
`endif
);

  // Settle counter only needs to hold SETTLE_CYCLES; keep at least one bit.
  localparam int SC_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  state_t           state;
  logic [1:0]       op_q;
  logic             a_q;
  logic             b_q;
  logic [SC_W-1:0]  settle_cnt;

  logic             y_exp;
  logic             mismatch;
  logic [CNT_W-1:0] vec_next;
  logic [CNT_W-1:0] fail_next;
  logic [3:0]       cov_next;

  gate_ref_model u_ref (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .y_exp (y_exp)
  );

  // Result values as they would be after the current CHECK cycle closes.
  // NOTE: every always_comb output is assigned unconditionally here, so no
  // path can leave a value held and infer a latch.
  always_comb begin
    mismatch  = (y != y_exp);
    vec_next  = (&vec_cnt) ? vec_cnt : vec_cnt + CNT_W'(1);
    fail_next = (mismatch && !(&fail_cnt)) ? fail_cnt + CNT_W'(1) : fail_cnt;
    cov_next  = coverage | (4'b0001 << {a_q, b_q});
  end

  assign busy = (state == ST_WAIT) || (state == ST_SETTLE) || (state == ST_CHECK);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_AND;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      settle_cnt <= '0;
      vec_cnt    <= '0;
      fail_cnt   <= '0;
      coverage   <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (start) begin
      // Start from any state restarts the run; an in-flight vector is dropped.
      state    <= ST_WAIT;
      op_q     <= op;
      vec_cnt  <= '0;
      fail_cnt <= '0;
      coverage <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (sample_valid) begin
            a_q <= a;
            b_q <= b;
            if (SETTLE_CYCLES == 0) begin
              state <= ST_CHECK;
            end else begin
              state      <= ST_SETTLE;
              settle_cnt <= SC_W'(SETTLE_CYCLES);
            end
          end
        end
        ST_SETTLE: begin
          // Loaded with SETTLE_CYCLES, so this state lasts exactly that many cycles.
          if (settle_cnt <= SC_W'(1)) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - SC_W'(1);
          end
        end
        ST_CHECK: begin
          vec_cnt  <= vec_next;
          fail_cnt <= fail_next;
          coverage <= cov_next;
          if (&cov_next) begin
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= (fail_next == '0);
          end else begin
            state <= ST_WAIT;
          end
        end
        default: ;  // IDLE and DONE hold until start
      endcase
    end
  end

`ifdef GATE_CHECKER_CAPTURE_EN
  // First mismatch of a run: fail_cnt still zero means none recorded yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail <= '0;
    end else if (start) begin
      first_fail <= '0;
    end else if (state == ST_CHECK && mismatch && fail_cnt == '0) begin
      first_fail <= {a_q, b_q, y};
    end
  end
`endif

endmodule

// File: tb/tb_gate_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_checker
// Three checker instances share clk/rst:
//   0: SETTLE_CYCLES=2, CNT_W=8   (default timing)
//   1: SETTLE_CYCLES=0, CNT_W=8   (zero settle)
//   2: SETTLE_CYCLES=1, CNT_W=2   (counter saturation)
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_gate_checker;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_i [N];
  logic       sv_i    [N];
  logic       a_i     [N];
  logic       b_i     [N];
  logic       y_i     [N];
  logic [1:0] op_i    [N];

  logic       d0_busy, d0_done, d0_pass, d1_busy, d1_done, d1_pass, d2_busy, d2_done, d2_pass;
  logic [7:0] d0_vec, d0_fail, d1_vec, d1_fail;
  logic [1:0] d2_vec, d2_fail;
  logic [3:0] d0_cov, d1_cov, d2_cov;
  logic [2:0] d0_ff, d1_ff, d2_ff;

  gate_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .start(start_i[0]), .op(op_i[0]), .sample_valid(sv_i[0]),
    .a(a_i[0]), .b(b_i[0]), .y(y_i[0]), .busy(d0_busy), .done(d0_done), .pass(d0_pass),
    .vec_cnt(d0_vec), .fail_cnt(d0_fail), .coverage(d0_cov)
`ifdef GATE_CHECKER_CAPTURE_EN
    , .first_fail(d0_ff)
`endif
  );

  gate_checker #(.SETTLE_CYCLES(0), .CNT_W(8)) u_fast (
    .clk(clk), .rst(rst), .start(start_i[1]), .op(op_i[1]), .sample_valid(sv_i[1]),
    .a(a_i[1]), .b(b_i[1]), .y(y_i[1]), .busy(d1_busy), .done(d1_done), .pass(d1_pass),
    .vec_cnt(d1_vec), .fail_cnt(d1_fail), .coverage(d1_cov)
`ifdef GATE_CHECKER_CAPTURE_EN
    , .first_fail(d1_ff)
`endif
  );

  gate_checker #(.SETTLE_CYCLES(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_i[2]), .op(op_i[2]), .sample_valid(sv_i[2]),
    .a(a_i[2]), .b(b_i[2]), .y(y_i[2]), .busy(d2_busy), .done(d2_done), .pass(d2_pass),
    .vec_cnt(d2_vec), .fail_cnt(d2_fail), .coverage(d2_cov)
`ifdef GATE_CHECKER_CAPTURE_EN
    , .first_fail(d2_ff)
`endif
  );

`ifndef GATE_CHECKER_CAPTURE_EN
  assign d0_ff = 3'b000;
  assign d1_ff = 3'b000;
  assign d2_ff = 3'b000;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Sampled outputs of the instance under test.
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_vec, o_fail;
  logic [3:0] o_cov;
  logic [2:0] o_ff;

  // Independent model of each instance.
  int         mdl_vec  [N];
  int         mdl_fail [N];
  logic [3:0] mdl_cov  [N];
  logic [2:0] mdl_ff   [N];
  logic [1:0] mdl_op   [N];

  typedef struct {
    int         vec;
    int         fail;
    logic [3:0] cov;
    logic       done;
    logic       pass;
    logic [2:0] ff;
  } exp_t;

  exp_t sb [$];

  function automatic int settle_of(int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 1);
  endfunction

  function automatic int max_of(int d);
    return (d == 2) ? 3 : 255;
  endfunction

  function automatic logic ref_y(logic [1:0] op, logic a, logic b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic sample(int d);
    case (d)
      0: begin o_busy = d0_busy; o_done = d0_done; o_pass = d0_pass; o_vec = d0_vec;
               o_fail = d0_fail; o_cov = d0_cov; o_ff = d0_ff; end
      1: begin o_busy = d1_busy; o_done = d1_done; o_pass = d1_pass; o_vec = d1_vec;
               o_fail = d1_fail; o_cov = d1_cov; o_ff = d1_ff; end
      default: begin o_busy = d2_busy; o_done = d2_done; o_pass = d2_pass;
               o_vec = {6'b0, d2_vec}; o_fail = {6'b0, d2_fail}; o_cov = d2_cov; o_ff = d2_ff; end
    endcase
  endtask

  task automatic drive(int d, logic s, logic v, logic aa, logic bb, logic yy);
    start_i[d] = s; sv_i[d] = v; a_i[d] = aa; b_i[d] = bb; y_i[d] = yy;
  endtask

  task automatic model_clear(int d, logic [1:0] op);
    mdl_vec[d] = 0; mdl_fail[d] = 0; mdl_cov[d] = 4'b0; mdl_ff[d] = 3'b0; mdl_op[d] = op;
  endtask

  // Pulse start at a falling edge; returns one cycle later on a falling edge.
  task automatic do_start(int d, logic [1:0] op);
    op_i[d] = op;
    drive(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    model_clear(d, op);
    @(negedge clk);
    start_i[d] = 1'b0;
    sample(d);
    n_checks++;
    if (o_busy !== 1'b1 || o_vec !== 8'd0 || o_fail !== 8'd0 || o_cov !== 4'b0 ||
        o_done !== 1'b0 || o_pass !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clear dut%0d: busy=%b vec=%0d fail=%0d cov=%b done=%b pass=%b, want busy=1 vec=0 fail=0 cov=0000 done=0 pass=0",
               d, o_busy, o_vec, o_fail, o_cov, o_done, o_pass);
    end
  endtask

  // Apply one vector, push the model's prediction, and check it when the
  // result is due. Starts and ends on a falling edge so calls chain back to back.
  task automatic send(int d, logic aa, logic bb, logic yy);
    exp_t e;
    int   prev_vec;
    int   prev_fail;
    logic mis;
    prev_vec  = mdl_vec[d];
    prev_fail = mdl_fail[d];
    mis = (yy !== ref_y(mdl_op[d], aa, bb));
    if (mis && mdl_fail[d] == 0) mdl_ff[d] = {aa, bb, yy};
    if (mdl_vec[d] < max_of(d)) mdl_vec[d]++;
    if (mis && mdl_fail[d] < max_of(d)) mdl_fail[d]++;
    mdl_cov[d] = mdl_cov[d] | (4'b0001 << {aa, bb});
    e.vec  = mdl_vec[d];
    e.fail = mdl_fail[d];
    e.cov  = mdl_cov[d];
    e.done = &mdl_cov[d];
    e.pass = e.done && (mdl_fail[d] == 0);
    e.ff   = mdl_ff[d];
    sb.push_back(e);

    drive(d, 1'b0, 1'b1, aa, bb, yy);
    op_i[d] = ~mdl_op[d];  // a mid-run op change must have no effect
    @(negedge clk);
    sv_i[d] = 1'b0;
    repeat (settle_of(d)) @(negedge clk);
    sample(d);
    n_checks++;
    if (o_vec !== 8'(prev_vec) || o_fail !== 8'(prev_fail)) begin
      n_fail++;
      $display("FAIL early_update dut%0d: vec=%0d fail=%0d before result edge, want vec=%0d fail=%0d",
               d, o_vec, o_fail, prev_vec, prev_fail);
    end
    @(negedge clk);
    sample(d);
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty dut%0d", d);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (o_vec !== 8'(e.vec)) begin
        n_fail++;
        $display("FAIL vec_cnt dut%0d: got %0d want %0d", d, o_vec, e.vec);
      end
      n_checks++;
      if (o_fail !== 8'(e.fail)) begin
        n_fail++;
        $display("FAIL fail_cnt dut%0d: got %0d want %0d", d, o_fail, e.fail);
      end
      n_checks++;
      if (o_cov !== e.cov) begin
        n_fail++;
        $display("FAIL coverage dut%0d: got %b want %b", d, o_cov, e.cov);
      end
      n_checks++;
      if (o_done !== e.done || o_pass !== e.pass || o_busy !== !e.done) begin
        n_fail++;
        $display("FAIL flags dut%0d: done=%b pass=%b busy=%b want done=%b pass=%b busy=%b",
                 d, o_done, o_pass, o_busy, e.done, e.pass, !e.done);
      end
`ifdef GATE_CHECKER_CAPTURE_EN
      n_checks++;
      if (o_ff !== e.ff) begin
        n_fail++;
        $display("FAIL first_fail dut%0d: got %b want %b", d, o_ff, e.ff);
      end
`endif
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < N; d++) begin
      sample(d);
      n_checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 || o_vec !== 8'd0 ||
          o_fail !== 8'd0 || o_cov !== 4'b0 || o_ff !== 3'b0) begin
        n_fail++;
        $display("FAIL reset_values dut%0d: busy=%b done=%b pass=%b vec=%0d fail=%0d cov=%b ff=%b, want all 0",
                 d, o_busy, o_done, o_pass, o_vec, o_fail, o_cov, o_ff);
      end
    end
    rst = 1'b0;
    // Vectors offered in IDLE must be ignored.
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    sv_i[0] = 1'b0;
    sample(0);
    n_checks++;
    if (o_busy !== 1'b0 || o_vec !== 8'd0 || o_cov !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: busy=%b vec=%0d cov=%b want busy=0 vec=0 cov=0000", o_busy, o_vec, o_cov);
    end
  endtask

  task automatic test_and_pass();
    do_start(0, 2'b00);
    send(0, 1'b0, 1'b0, 1'b0);
    send(0, 1'b0, 1'b1, 1'b0);
    send(0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_and_stuck();
    do_start(0, 2'b00);
    send(0, 1'b0, 1'b0, 1'b0);
    send(0, 1'b0, 1'b1, 1'b0);
    send(0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_xor_repeat();
    do_start(1, 2'b10);
    send(1, 1'b0, 1'b0, 1'b0);
    send(1, 1'b0, 1'b0, 1'b0);
    send(1, 1'b0, 1'b1, 1'b1);
    send(1, 1'b1, 1'b0, 1'b1);
    send(1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_restart();
    do_start(0, 2'b01);
    send(0, 1'b0, 1'b0, 1'b0);
    send(0, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);                 // vector accepted, now settling
    start_i[0] = 1'b1;              // restart with sample_valid still high
    model_clear(0, 2'b01);
    op_i[0] = 2'b01;
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample(0);
    n_checks++;
    if (o_busy !== 1'b1 || o_vec !== 8'd0 || o_fail !== 8'd0 || o_cov !== 4'b0) begin
      n_fail++;
      $display("FAIL restart_clear: busy=%b vec=%0d fail=%0d cov=%b want busy=1 vec=0 fail=0 cov=0000",
               o_busy, o_vec, o_fail, o_cov);
    end
    repeat (4) @(negedge clk);
    sample(0);
    n_checks++;
    if (o_vec !== 8'd0 || o_cov !== 4'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_discard: vec=%0d cov=%b busy=%b want vec=0 cov=0000 busy=1", o_vec, o_cov, o_busy);
    end
    send(0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_saturation();
    do_start(2, 2'b00);
    for (int i = 0; i < 5; i++) send(2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_settle();
    do_start(0, 2'b01);
    send(0, 1'b1, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    sv_i[0] = 1'b0;
    #2 rst = 1'b1;
    #1 sample(0);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 || o_vec !== 8'd0 ||
        o_fail !== 8'd0 || o_cov !== 4'b0 || o_ff !== 3'b0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b pass=%b vec=%0d fail=%0d cov=%b ff=%b, want all 0",
               o_busy, o_done, o_pass, o_vec, o_fail, o_cov, o_ff);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    sv_i[0] = 1'b0;
    sample(0);
    n_checks++;
    if (o_busy !== 1'b0 || o_vec !== 8'd0 || o_cov !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b vec=%0d cov=%b want busy=0 vec=0 cov=0000", o_busy, o_vec, o_cov);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < N; d++) begin
      drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      op_i[d] = 2'b00;
      model_clear(d, 2'b00);
    end
    @(negedge clk);
    test_reset();
    test_and_pass();
    test_and_stuck();
    test_xor_repeat();
    test_restart();
    test_saturation();
    test_reset_mid_settle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
